// File: rtl/div_complex_pkg.sv
// Shared constants and width helpers for the pipelined complex divider.
package div_complex_pkg;

  function automatic int lat(input int data_size);
    return data_size + 4;
  endfunction

  function automatic int num_w(input int data_size);
    return 2 * data_size + 2;
  endfunction

  function automatic int den_w(input int data_size);
    return 2 * data_size + 1;
  endfunction

endpackage

// File: rtl/div_pipe_unsigned.sv
// Pipelined unsigned restoring divider: one quotient bit per stage, MSB first,
// with a valid bit and an opaque side-band carried alongside each sample.
module div_pipe_unsigned #(
  parameter int NUM_W = 33,
  parameter int DEN_W = 33,
  parameter int Q_W   = 17,
  parameter int SB_W  = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  input  logic [NUM_W-1:0] i_num,
  input  logic [DEN_W-1:0] i_den,
  input  logic [SB_W-1:0]  i_side,
  output logic             o_valid,
  output logic [Q_W-1:0]   o_quot,
  output logic [SB_W-1:0]  o_side
);

  localparam int CMP_W = (NUM_W > DEN_W) ? NUM_W : DEN_W;

  for (genvar k = 0; k < Q_W; k++) begin : g_stage
    localparam int B = Q_W - 1 - k;

    logic [NUM_W-1:0] w_rem;
    logic [DEN_W-1:0] w_den;
    logic [Q_W-1:0]   w_q;
    logic [SB_W-1:0]  w_side;
    logic             w_vld;
    logic             w_ge;

    logic [NUM_W-1:0] r_rem;
    logic [Q_W-1:0]   r_q;
    logic [SB_W-1:0]  r_side;
    logic             r_vld;

    if (k == 0) begin : g_first
      assign w_rem  = i_num;
      assign w_den  = i_den;
      assign w_q    = '0;
      assign w_side = i_side;
      assign w_vld  = i_valid;
    end else begin : g_next
      assign w_rem  = g_stage[k-1].r_rem;
      assign w_den  = g_stage[k-1].g_den.r_den;
      assign w_q    = g_stage[k-1].r_q;
      assign w_side = g_stage[k-1].r_side;
      assign w_vld  = g_stage[k-1].r_vld;
    end

    // (rem >> B) >= den is the same test as rem >= den << B without widening rem.
    assign w_ge = CMP_W'(w_rem >> B) >= CMP_W'(w_den);

    always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
        r_vld  <= 1'b0;
        r_rem  <= '0;
        r_q    <= '0;
        r_side <= '0;
      end else begin
        r_vld  <= w_vld;
        r_rem  <= w_ge ? (w_rem - (NUM_W'(w_den) << B)) : w_rem;
        r_q    <= w_q | (Q_W'(w_ge) << B);
        r_side <= w_side;
      end
    end

    if (k < Q_W - 1) begin : g_den
      logic [DEN_W-1:0] r_den;
      always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) r_den <= '0;
        else          r_den <= w_den;
      end
    end
  end

  assign o_valid = g_stage[Q_W-1].r_vld;
  assign o_quot  = g_stage[Q_W-1].r_q;
  assign o_side  = g_stage[Q_W-1].r_side;

endmodule

// File: rtl/div_complex_pipe.sv
// Fully pipelined complex divider q = a / b, truncating toward zero with
// saturation and a zero result for a zero divisor; latency DATA_SIZE+4.
module div_complex_pipe
  import div_complex_pkg::*;
#(
  parameter int DATA_SIZE = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_valid,
  input  logic [DATA_SIZE-1:0] i_data_a_i,
  input  logic [DATA_SIZE-1:0] i_data_a_q,
  input  logic [DATA_SIZE-1:0] i_data_b_i,
  input  logic [DATA_SIZE-1:0] i_data_b_q,
  output logic [DATA_SIZE-1:0] o_data_i,
  output logic [DATA_SIZE-1:0] o_data_q,
  output logic                 o_valid
);

  localparam int NUM_W = num_w(DATA_SIZE);
  localparam int DEN_W = den_w(DATA_SIZE);
  localparam int MAG_W = NUM_W - 1;
  localparam int P_W   = 2 * DATA_SIZE;
  localparam int Q_W   = DATA_SIZE + 1;
  localparam logic [Q_W-1:0] POS_MAX = Q_W'((1 << (DATA_SIZE - 1)) - 1);
  localparam logic [Q_W-1:0] NEG_MAG = Q_W'(1 << (DATA_SIZE - 1));

  logic signed [P_W-1:0] r_p_aibi, r_p_aqbq, r_p_aqbi, r_p_aibq, r_p_bibi, r_p_bqbq;
  logic                  r_v1;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_v1     <= 1'b0;
      r_p_aibi <= '0;
      r_p_aqbq <= '0;
      r_p_aqbi <= '0;
      r_p_aibq <= '0;
      r_p_bibi <= '0;
      r_p_bqbq <= '0;
    end else begin
      r_v1     <= i_valid;
      r_p_aibi <= $signed(i_data_a_i) * $signed(i_data_b_i);
      r_p_aqbq <= $signed(i_data_a_q) * $signed(i_data_b_q);
      r_p_aqbi <= $signed(i_data_a_q) * $signed(i_data_b_i);
      r_p_aibq <= $signed(i_data_a_i) * $signed(i_data_b_q);
      r_p_bibi <= $signed(i_data_b_i) * $signed(i_data_b_i);
      r_p_bqbq <= $signed(i_data_b_q) * $signed(i_data_b_q);
    end
  end

  logic signed [NUM_W-1:0] w_num_re, w_num_im;
  logic        [DEN_W-1:0] w_den;
  logic        [MAG_W-1:0] w_mag_re, w_mag_im;

  assign w_num_re = NUM_W'(r_p_aibi) + NUM_W'(r_p_aqbq);
  assign w_num_im = NUM_W'(r_p_aqbi) - NUM_W'(r_p_aibq);
  assign w_den    = DEN_W'($unsigned(r_p_bibi)) + DEN_W'($unsigned(r_p_bqbq));
  assign w_mag_re = w_num_re[NUM_W-1] ? MAG_W'(-w_num_re) : MAG_W'(w_num_re);
  assign w_mag_im = w_num_im[NUM_W-1] ? MAG_W'(-w_num_im) : MAG_W'(w_num_im);

  logic [MAG_W-1:0] r_mag_re, r_mag_im;
  logic [DEN_W-1:0] r_den;
  logic             r_sgn_re, r_sgn_im, r_zero, r_v2;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_v2     <= 1'b0;
      r_mag_re <= '0;
      r_mag_im <= '0;
      r_den    <= '0;
      r_sgn_re <= 1'b0;
      r_sgn_im <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      r_v2     <= r_v1;
      r_mag_re <= w_mag_re;
      r_mag_im <= w_mag_im;
      r_den    <= w_den;
      r_sgn_re <= w_num_re[NUM_W-1];
      r_sgn_im <= w_num_im[NUM_W-1];
      r_zero   <= (w_den == '0);
    end
  end

  logic             w_vld_re, w_vld_im;
  logic [Q_W-1:0]   w_q_re, w_q_im;
  logic [1:0]       w_sb_re, w_sb_im;

  div_pipe_unsigned #(.NUM_W(MAG_W), .DEN_W(DEN_W), .Q_W(Q_W), .SB_W(2)) u_div_re (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_valid (r_v2),
    .i_num   (r_mag_re),
    .i_den   (r_den),
    .i_side  ({r_sgn_re, r_zero}),
    .o_valid (w_vld_re),
    .o_quot  (w_q_re),
    .o_side  (w_sb_re)
  );

  div_pipe_unsigned #(.NUM_W(MAG_W), .DEN_W(DEN_W), .Q_W(Q_W), .SB_W(2)) u_div_im (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_valid (r_v2),
    .i_num   (r_mag_im),
    .i_den   (r_den),
    .i_side  ({r_sgn_im, r_zero}),
    .o_valid (w_vld_im),
    .o_quot  (w_q_im),
    .o_side  (w_sb_im)
  );

  // Any quotient of 2^(DATA_SIZE+1) or more still leaves the top bit set, so it saturates.
  function automatic logic [DATA_SIZE-1:0] restore(input logic [Q_W-1:0] q,
                                                   input logic sgn, input logic zero);
    if (zero) return '0;
    if (sgn)  return (q >= NEG_MAG) ? {1'b1, {(DATA_SIZE-1){1'b0}}} : DATA_SIZE'(-q);
    return (q > POS_MAX) ? {1'b0, {(DATA_SIZE-1){1'b1}}} : DATA_SIZE'(q);
  endfunction

  logic w_vld;
  assign w_vld = w_vld_re & w_vld_im;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_valid  <= 1'b0;
      o_data_i <= '0;
      o_data_q <= '0;
    end else begin
      o_valid <= w_vld;
      if (w_vld) begin
        o_data_i <= restore(w_q_re, w_sb_re[1], w_sb_re[0]);
        o_data_q <= restore(w_q_im, w_sb_im[1], w_sb_im[0]);
      end
    end
  end

endmodule

// File: tb/tb_div_complex_pipe.sv
// Self-checking bench for div_complex_pipe: vector table, reset and gapped sequences,
// results checked through a cycle-stamped scoreboard.
module tb_div_complex_pipe;
  import div_complex_pkg::*;

  localparam int DS  = 16;
  localparam int LAT = lat(DS);

  logic          clk = 1'b0;
  logic          i_reset, i_valid;
  logic [DS-1:0] ai, aq, bi, bq;
  logic [DS-1:0] o_data_i, o_data_q;
  logic          o_valid;

  div_complex_pipe #(.DATA_SIZE(DS)) dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_valid    (i_valid),
    .i_data_a_i (ai),
    .i_data_a_q (aq),
    .i_data_b_i (bi),
    .i_data_b_q (bq),
    .o_data_i   (o_data_i),
    .o_data_q   (o_data_q),
    .o_valid    (o_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DS-1:0] ai, aq, bi, bq, ei, eq;
  } vec_t;

  typedef struct {
    int            due;
    logic [DS-1:0] ei, eq;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // A sample driven before posedge c+1 leaves the last register at posedge c+LAT,
  // which the negedge checker sees while cyc == c+LAT.
  always @(negedge clk) begin
    logic exp_v;
    exp_t e;
    exp_v = (sb.size() > 0) && (sb[0].due == cyc);
    n_chk++;
    if (o_valid !== exp_v) begin
      n_fail++;
      $display("FAIL o_valid @cyc %0d: got %b, required %b", cyc, o_valid, exp_v);
    end
    if (exp_v) begin
      e = sb.pop_front();
      if (o_valid === 1'b1) begin
        n_chk++;
        if (o_data_i !== e.ei) begin
          n_fail++;
          $display("FAIL o_data_i @cyc %0d: got %0d, required %0d", cyc, $signed(o_data_i), $signed(e.ei));
        end
        n_chk++;
        if (o_data_q !== e.eq) begin
          n_fail++;
          $display("FAIL o_data_q @cyc %0d: got %0d, required %0d", cyc, $signed(o_data_q), $signed(e.eq));
        end
      end
    end
  end

  function automatic vec_t mk(input int a_i, input int a_q, input int b_i, input int b_q,
                              input int e_i, input int e_q);
    vec_t v;
    v.ai = DS'(a_i); v.aq = DS'(a_q); v.bi = DS'(b_i); v.bq = DS'(b_q);
    v.ei = DS'(e_i); v.eq = DS'(e_q);
    return v;
  endfunction

  function automatic logic [DS-1:0] ref_q(input longint n, input longint d);
    longint q;
    if (d == 0) return '0;
    q = n / d;
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return q[DS-1:0];
  endfunction

  function automatic vec_t ref_vec(input logic [DS-1:0] a_i, a_q, b_i, b_q);
    vec_t   v;
    longint xi, xq, yi, yq, den;
    xi = longint'($signed(a_i)); xq = longint'($signed(a_q));
    yi = longint'($signed(b_i)); yq = longint'($signed(b_q));
    den = yi * yi + yq * yq;
    v.ai = a_i; v.aq = a_q; v.bi = b_i; v.bq = b_q;
    v.ei = ref_q(xi * yi + xq * yq, den);
    v.eq = ref_q(xq * yi - xi * yq, den);
    return v;
  endfunction

  task automatic drive(input logic v, input vec_t s);
    @(negedge clk);
    i_valid = v;
    ai = s.ai; aq = s.aq; bi = s.bi; bq = s.bq;
    if (v) sb.push_back('{due: cyc + LAT, ei: s.ei, eq: s.eq});
  endtask

  task automatic idle();
    drive(1'b0, mk(int'($urandom_range(0, 65535)), 3, 5, 7, 0, 0));
  endtask

  task automatic drain();
    int unsigned k = 0;
    while (sb.size() > 0 && k < LAT + 10) begin
      @(negedge clk);
      k++;
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    n_chk++;
    if (o_valid !== 1'b0 || o_data_i !== '0 || o_data_q !== '0) begin
      n_fail++;
      $display("FAIL %s: got valid=%b i=%0d q=%0d, required 0 0 0", tag, o_valid, o_data_i, o_data_q);
    end
  endtask

  vec_t tbl[11];

  initial begin
    tbl[0]  = mk(740, 740, 10, 10, 74, 0);
    tbl[1]  = mk(1000, 0, 200, 10, 4, 0);
    tbl[2]  = mk(740, 45, 0, 156, 0, -4);
    tbl[3]  = mk(789, 65, 4, 1, 189, -31);
    tbl[4]  = mk(-789, -65, 4, 1, -189, 31);
    tbl[5]  = mk(7, 0, -2, 0, -3, 0);
    tbl[6]  = mk(-32768, -32768, 1, 0, -32768, -32768);
    tbl[7]  = mk(32767, 32767, 0, 1, 32767, -32767);
    tbl[8]  = mk(100, 100, 0, 0, 0, 0);
    tbl[9]  = mk(-32768, 0, -1, 0, 32767, 0);
    tbl[10] = mk(32767, 32767, 1, 0, 32767, 32767);

    i_reset = 1'b0; i_valid = 1'b0; ai = '0; aq = '0; bi = '0; bq = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("initial_reset");
    i_reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) drive(1'b1, tbl[i]);
    idle();
    drain();

    for (int i = 4; i < 11; i++) begin
      drive(1'b1, tbl[i]);
      idle();
    end
    drain();

    for (int i = 0; i < 3; i++) drive(1'b1, tbl[i]);
    idle();
    idle();
    @(negedge clk);
    i_reset = 1'b0;
    i_valid = 1'b0;
    sb.delete();
    #1 check_reset_outputs("reset_assert");
    @(negedge clk);
    check_reset_outputs("reset_hold");
    i_reset = 1'b1;
    repeat (LAT + 5) @(negedge clk);
    drive(1'b1, tbl[0]);
    idle();
    drain();

    for (int i = 0; i < 40; i++) begin
      vec_t r;
      r = ref_vec(DS'($urandom), DS'($urandom), DS'($urandom_range(0, 65535) >> (i % 16)),
                  DS'($urandom_range(0, 65535) >> ((i * 5) % 16)));
      drive(1'b1, r);
      idle();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
